halt_dump_ctrl: RTL and testbench

//  In-core run-control block. It watches the memory-stage instruction for the HALT opcode and runs a

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/halt_dump_ctrl_if.sv | 32 +++
 rtl/cycle_watchdog.sv | 37 +++
 rtl/halt_dump_ctrl.sv | 105 ++++++++++
 tb/tb_halt_dump_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared run-control definitions: data path defaults,
// halt opcode and dump FSM state encoding.
package run_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam logic [15:0] DEF_HALT_OPCODE = 16'hF000;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_RD,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/halt_dump_ctrl_if.sv
// Valid/ready dump stream carrying one memory word
// with its address and end-of-dump marker.
interface halt_dump_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (
    output valid,
    output addr,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/cycle_watchdog.sv
// Saturating cycle counter; fire holds once the limit
// is reached. A limit of 0 never fires.
module cycle_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic fire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT =
    (TIMEOUT_CYCLES == 0) ? '1 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          top;

  assign top = (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (en && !top) begin
      cnt <= cnt + 1'b1;
    end
  end

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign fire = 1'b0;
  end else begin : g_on
    assign fire = top;
  end

endmodule

// File: rtl/halt_dump_ctrl.sv
// Run control: stalls the core on HALT or watchdog
// expiry, then streams data memory out word by word.
module halt_dump_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_OPCODE =
    DATA_W'(DEF_HALT_OPCODE),
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DUMP_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_instr,
  output logic              cpu_stall,
  output logic              dm_rd_en,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_rdata,
  halt_dump_ctrl_if.master  dump,
  output logic              halted,
  output logic              timeout,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DUMP_DEPTH - 1);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              d_last;
  logic              run;
  logic              hit;
  logic              fire;
  logic              accept;

  assign run    = (state == ST_RUN);
  assign hit    = run && (mem_instr == HALT_OPCODE);
  assign accept = (state == ST_SEND) && dump.ready;

  cycle_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clear(!run),
    .fire (fire)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_RUN:  if (hit || fire) nxt = ST_RD;
      ST_RD:   nxt = ST_WAIT;
      ST_WAIT: nxt = ST_SEND;
      ST_SEND: if (dump.ready) nxt = d_last ? ST_DONE : ST_RD;
      ST_DONE: nxt = ST_DONE;
      default: nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_RUN;
      addr    <= '0;
      d_addr  <= '0;
      d_data  <= '0;
      d_last  <= 1'b0;
      halted  <= 1'b0;
      timeout <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nxt;
      // halt takes priority over a coincident expiry
      if (hit) begin
        halted <= 1'b1;
      end else if (run && fire) begin
        halted  <= 1'b1;
        timeout <= 1'b1;
      end
      if (state == ST_WAIT) begin
        d_data <= dm_rdata;
        d_addr <= addr;
        d_last <= (addr == LAST);
      end
      if (accept) begin
        if (d_last) done <= 1'b1;
        else        addr <= addr + 1'b1;
      end
    end
  end

  assign cpu_stall  = !run;
  assign dm_rd_en   = (state == ST_RD);
  assign dm_addr    = dm_rd_en ? addr : '0;
  assign dump.valid = (state == ST_SEND);
  assign dump.addr  = d_addr;
  assign dump.data  = d_data;
  assign dump.last  = d_last;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Directed bench for halt_dump_ctrl: default build
// plus a one-word, watchdog-off build.
module tb_halt_dump_ctrl;
  import run_ctrl_pkg::*;

  localparam logic [15:0] HALT = 16'hF000;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [15:0] instr_a, instr_b;
  logic        stall_a, stall_b;
  logic        rd_a, rd_b;
  logic [7:0]  daddr_a, daddr_b;
  logic [15:0] rdata_a, rdata_b;
  logic        halted_a, halted_b;
  logic        to_a, to_b;
  logic        done_a, done_b;
  logic [15:0] mem [256];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  halt_dump_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifa ();
  halt_dump_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

  halt_dump_ctrl u_a (
    .clk(clk), .rst(rst_a), .mem_instr(instr_a),
    .cpu_stall(stall_a), .dm_rd_en(rd_a),
    .dm_addr(daddr_a), .dm_rdata(rdata_a),
    .dump(ifa), .halted(halted_a),
    .timeout(to_a), .done(done_a)
  );

  halt_dump_ctrl #(
    .TIMEOUT_CYCLES(0), .DUMP_DEPTH(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .mem_instr(instr_b),
    .cpu_stall(stall_b), .dm_rd_en(rd_b),
    .dm_addr(daddr_b), .dm_rdata(rdata_b),
    .dump(ifb), .halted(halted_b),
    .timeout(to_b), .done(done_b)
  );

  always @(posedge clk) if (rd_a) rdata_a <= mem[daddr_a];
  always @(posedge clk) if (rd_b) rdata_b <= mem[daddr_b];

  function automatic logic [15:0] exp_word(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_a();
    @(negedge clk) rst_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
  endtask

  task automatic halt_a();
    instr_a = HALT;
    @(negedge clk) instr_a = 16'h0;
  endtask

  // mode 0: always ready; mode 1: random with a
  // 10-cycle stall on word 3. Stops when word stop_at shows.
  task automatic run_dump(input int mode,
                          input int stop_at,
                          output int n);
    int  hold = 0;
    int  cyc = 0;
    bit  fin = 1'b0;
    n = 0;
    while (!fin && cyc < 6000) begin
      if (ifa.valid) begin
        chk("addr", 32'(ifa.addr), n);
        chk("data", 32'(ifa.data), 32'(exp_word(n)));
        chk("last", 32'(ifa.last), 32'(n == 255));
        if (n == stop_at) begin
          ifa.ready = 1'b0;
          fin = 1'b1;
        end else begin
          if (mode == 0) ifa.ready = 1'b1;
          else if (n == 3 && hold < 10) begin
            ifa.ready = 1'b0;
            hold++;
          end else ifa.ready = 1'($urandom_range(0, 1));
          if (ifa.ready) n++;
        end
      end else if (mode == 1) begin
        ifa.ready = 1'($urandom_range(0, 1));
      end
      if (!fin) begin
        if (done_a) fin = 1'b1;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (!fin) chk("dump_budget", 0, 1);
  endtask

  initial begin
    int n;
    int cnt;
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = exp_word(i);
    rst_a = 1'b0; rst_b = 1'b0;
    instr_a = '0; instr_b = '0;
    ifa.ready = 1'b0; ifb.ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall_a), 0);
    chk("rst_halted", 32'(halted_a), 0);
    chk("rst_timeout", 32'(to_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_valid", 32'(ifa.valid), 0);
    chk("rst_rd", 32'(rd_a), 0);
    chk("rst_last", 32'(ifa.last), 0);
    chk("rst_daddr", 32'(ifa.addr), 0);
    chk("rst_ddata", 32'(ifa.data), 0);
    rst_a = 1'b1;

    repeat (5) @(negedge clk);
    instr_a = HALT;
    ifa.ready = 1'b1;
    @(negedge clk);
    chk("lat_stall", 32'(stall_a), 1);
    chk("lat_halted", 32'(halted_a), 1);
    chk("lat_rd", 32'(rd_a), 1);
    chk("lat_rdaddr", 32'(daddr_a), 0);
    chk("lat_valid0", 32'(ifa.valid), 0);
    instr_a = 16'h0;
    @(negedge clk);
    chk("lat_valid1", 32'(ifa.valid), 0);
    chk("lat_rd1", 32'(rd_a), 0);
    @(negedge clk);
    chk("lat_valid2", 32'(ifa.valid), 1);
    run_dump(0, -1, n);
    chk("full_count", n, 256);
    chk("full_done", 32'(done_a), 1);
    chk("full_timeout", 32'(to_a), 0);
    chk("full_halted", 32'(halted_a), 1);

    instr_a = HALT;
    repeat (3) @(negedge clk);
    chk("term_valid", 32'(ifa.valid), 0);
    chk("term_stall", 32'(stall_a), 1);
    chk("term_rd", 32'(rd_a), 0);
    chk("term_done", 32'(done_a), 1);
    instr_a = 16'h0;

    reset_a();
    ifa.ready = 1'b0;
    repeat (2) @(negedge clk);
    halt_a();
    run_dump(1, -1, n);
    chk("bp_count", n, 256);
    chk("bp_done", 32'(done_a), 1);

    reset_a();
    halt_a();
    run_dump(0, 40, n);
    chk("mid_stop", n, 40);
    rst_a = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(ifa.valid), 0);
    chk("mid_halted", 32'(halted_a), 0);
    chk("mid_stall", 32'(stall_a), 0);
    rst_a = 1'b1;
    @(negedge clk);
    halt_a();
    run_dump(0, 0, n);
    chk("mid_restart", n, 0);

    @(negedge clk) rst_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
    cnt = 1;
    while (!rd_a && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk("wd_cycles", cnt, 1001);
    chk("wd_timeout", 32'(to_a), 1);
    chk("wd_halted", 32'(halted_a), 1);

    @(negedge clk) rst_a = 1'b0;
    @(negedge clk) rst_a = 1'b1;
    repeat (999) @(negedge clk);
    chk("tie_pre_rd", 32'(rd_a), 0);
    instr_a = HALT;
    @(negedge clk);
    instr_a = 16'h0;
    chk("tie_rd", 32'(rd_a), 1);
    chk("tie_halted", 32'(halted_a), 1);
    chk("tie_timeout", 32'(to_a), 0);

    rst_b = 1'b1;
    seen = 0;
    repeat (5000) begin
      @(negedge clk);
      if (rd_b || stall_b || halted_b) seen++;
    end
    chk("b_idle", seen, 0);
    instr_b = HALT;
    @(negedge clk) instr_b = 16'h0;
    cnt = 0;
    while (!ifb.valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b_valid", 32'(ifb.valid), 1);
    chk("b_addr", 32'(ifb.addr), 0);
    chk("b_data", 32'(ifb.data), 32'(exp_word(0)));
    chk("b_last", 32'(ifb.last), 1);
    ifb.ready = 1'b1;
    @(negedge clk);
    chk("b_done", 32'(done_b), 1);
    chk("b_valid_off", 32'(ifb.valid), 0);
    chk("b_timeout", 32'(to_b), 0);
    chk("b_halted", 32'(halted_b), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
